// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared PC-unit constants, next-PC select enum and branch-target helper
package mips_pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int          MAX_ADDR_W    = 64;

  typedef enum logic [2:0] {
    RST,
    EXC,
    JR,
    JMP,
    BR,
    HOLD,
    SEQ
  } next_pc_sel_t;

  // Computed at full width; callers truncate to their ADDR_W so the add wraps modulo 2^ADDR_W.
  function automatic logic [MAX_ADDR_W-1:0] branch_target(
    input logic [MAX_ADDR_W-1:0] pc,
    input logic [15:0]           imm
  );
    logic [MAX_ADDR_W-1:0] offset;
    offset = {{(MAX_ADDR_W-18){imm[15]}}, imm, 2'b00};
    return pc + MAX_ADDR_W'(4) + offset;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with overwrite-on-full and flush
module pc_ras
  import mips_pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] data,
  output logic [ADDR_W-1:0] top,
  output logic              valid
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;

  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && (!pop || empty)) begin
      // When full the pointer lands on the oldest slot, so it is overwritten in place.
      mem[ptr + PTR_W'(1)] <= data;
      ptr                  <= ptr + PTR_W'(1);
      if (count != FULL) count <= count + CNT_W'(1);
    end else if (push) begin
      mem[ptr] <= data;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  assign valid = !empty;
  assign top   = empty ? '0 : mem[ptr];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with redirect priority mux and return-address stack
module pc_unit
  import mips_pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_exc,
  input  logic              i_jr,
  input  logic [ADDR_W-1:0] i_jr_addr,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_idx,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic [15:0]       i_branch_imm,
  input  logic              i_ras_push,
  input  logic [ADDR_W-1:0] i_link_addr,
  input  logic              i_ras_pop,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_redirect,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_ras_top,
  output logic              o_ras_valid
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect_q;
  logic              misalign_q;
  next_pc_sel_t      sel;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign jr_target = {i_jr_addr[ADDR_W-1:2], 2'b00};
  assign br_target = ADDR_W'(branch_target(MAX_ADDR_W'(i_branch_pc), i_branch_imm));

  // J/JAL keeps the region bits of the delay-slot PC above the 28-bit index window.
  generate
    if (ADDR_W > 28) begin : g_jmp_region
      assign jmp_target = {pc_plus4[ADDR_W-1:28], i_jump_idx, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_target = {i_jump_idx, 2'b00};
    end
  endgenerate

  always_comb begin
    sel = SEQ;
    if (i_exc)         sel = EXC;
    else if (i_jr)     sel = JR;
    else if (i_jump)   sel = JMP;
    else if (i_branch) sel = BR;
    else if (i_stall)  sel = HOLD;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      EXC:     next_pc = ADDR_W'(EXC_VEC);
      JR:      next_pc = jr_target;
      JMP:     next_pc = jmp_target;
      BR:      next_pc = br_target;
      HOLD:    next_pc = pc_q;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= ADDR_W'(RESET_VEC);
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      redirect_q <= (sel == EXC) || (sel == JR) || (sel == JMP) || (sel == BR);
      misalign_q <= (sel == JR) && (i_jr_addr[1:0] != 2'b00);
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4;
  assign o_redirect = redirect_q;
  assign o_misalign = misalign_q;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_ras_push),
    .pop   (i_ras_pop),
    .flush (i_exc),
    .data  (i_link_addr),
    .top   (o_ras_top),
    .valid (o_ras_valid)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit: sequencing, stall, priority, wrap, RAS, reset
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, exc, jr, jump, branch, ras_push, ras_pop;
  logic [31:0] jr_addr, branch_pc, link_addr;
  logic [25:0] jump_idx;
  logic [15:0] branch_imm;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        redirect, misalign, ras_valid;

  typedef struct {
    logic        stall;
    logic        exc;
    logic        jr;
    logic [31:0] jr_addr;
    logic        jump;
    logic [25:0] jump_idx;
    logic        branch;
    logic [31:0] bpc;
    logic [15:0] bimm;
    logic        push;
    logic        pop;
    logic [31:0] link;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic        mis;
    logic        rv;
    logic [31:0] rt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_unit #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0080),
    .RAS_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_exc        (exc),
    .i_jr         (jr),
    .i_jr_addr    (jr_addr),
    .i_jump       (jump),
    .i_jump_idx   (jump_idx),
    .i_branch     (branch),
    .i_branch_pc  (branch_pc),
    .i_branch_imm (branch_imm),
    .i_ras_push   (ras_push),
    .i_link_addr  (link_addr),
    .i_ras_pop    (ras_pop),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .o_redirect   (redirect),
    .o_misalign   (misalign),
    .o_ras_top    (ras_top),
    .o_ras_valid  (ras_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic stim_t idle_row(input logic hold);
    stim_t s;
    s = '{hold, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0};
    return s;
  endfunction

  function automatic stim_t ras_row(input logic push, input logic pop, input logic [31:0] link);
    stim_t s;
    s = idle_row(1'b1);
    s.push = push;
    s.pop  = pop;
    s.link = link;
    return s;
  endfunction

  function automatic string obs();
    return $sformatf("pc=%h redir=%b mis=%b rv=%b top=%h", pc, redirect, misalign, ras_valid, ras_top);
  endfunction

  function automatic string exps(input exp_t e);
    return $sformatf("pc=%h redir=%b mis=%b rv=%b top=%h", e.pc, e.redir, e.mis, e.rv, e.rt);
  endfunction

  task automatic apply(input stim_t s);
    stall      = s.stall;
    exc        = s.exc;
    jr         = s.jr;
    jr_addr    = s.jr_addr;
    jump       = s.jump;
    jump_idx   = s.jump_idx;
    branch     = s.branch;
    branch_pc  = s.bpc;
    branch_imm = s.bimm;
    ras_push   = s.push;
    ras_pop    = s.pop;
    link_addr  = s.link;
  endtask

  task automatic row(input stim_t s, input exp_t e);
    apply(s);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(idle_row(1'b0));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0 || redirect !== 1'b0 || misalign !== 1'b0 || ras_valid !== 1'b0 || ras_top !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold got %s", obs());
    end
    rst_n = 1'b1;
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_release got pc=%h plus4=%h want pc=0 plus4=4", pc, pc_plus4);
    end
    for (int i = 1; i <= 3; i++) begin
      row(idle_row(1'b0), '{32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0});
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL sequential[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_stall_branch();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = idle_row(1'b0); st[0].jr = 1'b1; st[0].jr_addr = 32'h100;
    st[1] = idle_row(1'b1);
    st[2] = idle_row(1'b1);
    st[3] = idle_row(1'b1); st[3].branch = 1'b1; st[3].bpc = 32'h0F8; st[3].bimm = 16'hFFFE;
    st[4] = idle_row(1'b0);
    ex = '{'{32'h100, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h100, 1'b0, 1'b0, 1'b0, 32'h0},
           '{32'h100, 1'b0, 1'b0, 1'b0, 32'h0}, '{32'h0F4, 1'b1, 1'b0, 1'b0, 32'h0},
           '{32'h0F8, 1'b0, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 5; i++) begin
      row(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL stall_branch[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 26'h123, 1'b1, 32'h40, 16'h0001, 1'b0, 1'b0, 32'h0};
    st[1] = idle_row(1'b0); st[1].jr = 1'b1; st[1].jr_addr = 32'h203;
    st[2] = idle_row(1'b0); st[2].jr = 1'b1; st[2].jr_addr = 32'h200; st[2].jump = 1'b1; st[2].jump_idx = 26'h55;
    st[3] = idle_row(1'b0); st[3].jump = 1'b1; st[3].jump_idx = 26'h10; st[3].branch = 1'b1; st[3].bimm = 16'h0010;
    st[4] = idle_row(1'b1); st[4].branch = 1'b1; st[4].bpc = 32'h1000; st[4].bimm = 16'h0008;
    ex = '{'{32'h080, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h200, 1'b1, 1'b1, 1'b0, 32'h0},
           '{32'h200, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h040, 1'b1, 1'b0, 1'b0, 32'h0},
           '{32'h1024, 1'b1, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 5; i++) begin
      row(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL priority[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_wrap_jump();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  e;
    st[0] = idle_row(1'b0); st[0].jr = 1'b1; st[0].jr_addr = 32'hFFFF_FFFC;
    st[1] = idle_row(1'b0);
    st[2] = idle_row(1'b0); st[2].branch = 1'b1; st[2].bpc = 32'hFFFF_FFF8; st[2].bimm = 16'h0004;
    st[3] = idle_row(1'b0); st[3].jr = 1'b1; st[3].jr_addr = 32'h0FFF_FFFC;
    st[4] = idle_row(1'b0); st[4].jump = 1'b1; st[4].jump_idx = 26'h0000040;
    st[5] = idle_row(1'b0); st[5].jr = 1'b1; st[5].jr_addr = 32'h1000_0000;
    st[6] = idle_row(1'b0); st[6].jump = 1'b1; st[6].jump_idx = 26'h3FF_FFFF;
    ex = '{'{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0},
           '{32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h0FFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0},
           '{32'h1000_0100, 1'b1, 1'b0, 1'b0, 32'h0}, '{32'h1000_0000, 1'b1, 1'b0, 1'b0, 32'h0},
           '{32'h1FFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 7; i++) begin
      row(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL wrap_jump[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_ras();
    stim_t st[13];
    exp_t  ex[13];
    exp_t  e;
    st[0] = ras_row(1'b1, 1'b0, 32'hA000_0004); st[0].jr = 1'b1; st[0].jr_addr = 32'h400;
    st[1]  = ras_row(1'b1, 1'b0, 32'hB000_0008);
    st[2]  = ras_row(1'b1, 1'b0, 32'hC000_000C);
    st[3]  = ras_row(1'b1, 1'b0, 32'hD000_0010);
    st[4]  = ras_row(1'b1, 1'b0, 32'hE000_0014);
    st[5]  = ras_row(1'b0, 1'b1, 32'h0);
    st[6]  = ras_row(1'b0, 1'b1, 32'h0);
    st[7]  = ras_row(1'b0, 1'b1, 32'h0);
    st[8]  = ras_row(1'b0, 1'b1, 32'h0);
    st[9]  = ras_row(1'b0, 1'b1, 32'h0);
    st[10] = ras_row(1'b1, 1'b1, 32'h0000_ABC0);
    st[11] = ras_row(1'b1, 1'b1, 32'h0000_DEF0);
    st[12] = ras_row(1'b0, 1'b1, 32'h0);
    ex = '{'{32'h400, 1'b1, 1'b0, 1'b1, 32'hA000_0004}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'hB000_0008},
           '{32'h400, 1'b0, 1'b0, 1'b1, 32'hC000_000C}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'hD000_0010},
           '{32'h400, 1'b0, 1'b0, 1'b1, 32'hE000_0014}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'hD000_0010},
           '{32'h400, 1'b0, 1'b0, 1'b1, 32'hC000_000C}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'hB000_0008},
           '{32'h400, 1'b0, 1'b0, 1'b0, 32'h0},         '{32'h400, 1'b0, 1'b0, 1'b0, 32'h0},
           '{32'h400, 1'b0, 1'b0, 1'b1, 32'h0000_ABC0}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'h0000_DEF0},
           '{32'h400, 1'b0, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 13; i++) begin
      row(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL ras[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_exc_flush();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  e;
    st[0] = ras_row(1'b1, 1'b0, 32'h0000_111C);
    st[1] = ras_row(1'b1, 1'b0, 32'h0000_2220);
    st[2] = ras_row(1'b1, 1'b0, 32'h0000_9990); st[2].exc = 1'b1;
    st[3] = ras_row(1'b0, 1'b1, 32'h0);
    st[4] = ras_row(1'b1, 1'b0, 32'h0000_3330);
    st[5] = ras_row(1'b0, 1'b1, 32'h0);
    ex = '{'{32'h400, 1'b0, 1'b0, 1'b1, 32'h0000_111C}, '{32'h400, 1'b0, 1'b0, 1'b1, 32'h0000_2220},
           '{32'h080, 1'b1, 1'b0, 1'b0, 32'h0},         '{32'h080, 1'b0, 1'b0, 1'b0, 32'h0},
           '{32'h080, 1'b0, 1'b0, 1'b1, 32'h0000_3330}, '{32'h080, 1'b0, 1'b0, 1'b0, 32'h0}};
    for (int i = 0; i < 6; i++) begin
      row(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
        errors++;
        $display("FAIL exc_flush[%0d] got %s want %s", i, obs(), exps(e));
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    exp_t  e;
    s = ras_row(1'b1, 1'b0, 32'h0000_5550);
    s.jr = 1'b1;
    s.jr_addr = 32'h303;
    row(s, '{32'h300, 1'b1, 1'b1, 1'b1, 32'h0000_5550});
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
      errors++;
      $display("FAIL pre_reset got %s want %s", obs(), exps(e));
    end
    apply(idle_row(1'b1));
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || redirect !== 1'b0 || misalign !== 1'b0 || ras_valid !== 1'b0 || ras_top !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got %s want pc=0 redir=0 mis=0 rv=0 top=0", obs());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    row(idle_row(1'b0), '{32'h4, 1'b0, 1'b0, 1'b0, 32'h0});
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.pc || redirect !== e.redir || misalign !== e.mis || ras_valid !== e.rv || ras_top !== e.rt) begin
      errors++;
      $display("FAIL post_reset got %s want %s", obs(), exps(e));
    end
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_priority();
    test_wrap_jump();
    test_ras();
    test_exc_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage, replacing the plain PC register. Each cycle it selects the next fetch address from reset vector, exception vector, jump-register, jump, taken-branch, hold (stall) or sequential increment. It also holds a small return-address stack (RAS) that decode uses to predict `jr $ra` targets. `o_pc` drives instruction-memory addressing.

## Interface
- `ADDR_W`, 32: PC width in bits; must be ≥ 28.
- `RESET_VEC`, 32'h0000_0000: `o_pc` value during and after reset (truncated to `ADDR_W`).
- `EXC_VEC`, 32'h0000_0080: exception handler address.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥ 2.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_stall` in 1: hold `o_pc`; blocks only the sequential increment.
- `i_exc` in 1: exception redirect to `EXC_VEC`.
- `i_jr` in 1: jump-register redirect.
- `i_jr_addr` in `ADDR_W`: register target.
- `i_jump` in 1: J/JAL redirect.
- `i_jump_idx` in 26: instr_index field.
- `i_branch` in 1: taken-branch redirect.
- `i_branch_pc` in `ADDR_W`: PC of the branch instruction.
- `i_branch_imm` in 16: branch immediate.
- `i_ras_push` in 1: push `i_link_addr` (JAL/JALR).
- `i_link_addr` in `ADDR_W`: return address to push.
- `i_ras_pop` in 1: pop top (`jr $ra` predicted).
- `o_pc` out `ADDR_W`: current fetch address.
- `o_pc_plus4` out `ADDR_W`: `o_pc` + 4, combinational.
- `o_redirect` out 1: `o_pc` was loaded by a redirect on the last edge.
- `o_misalign` out 1: last loaded JR target had nonzero bits [1:0].
- `o_ras_top` out `ADDR_W`: top RAS entry; 0 when empty.
- `o_ras_valid` out 1: RAS non-empty.

## Operation
- Next-PC priority, highest first:
  - `i_exc` → `EXC_VEC`
  - `i_jr` → `{i_jr_addr[ADDR_W-1:2], 2'b00}`
  - `i_jump` → `{(o_pc+4)[ADDR_W-1:28], i_jump_idx, 2'b00}`
  - `i_branch` → `i_branch_pc + 4 + (sext(i_branch_imm) << 2)`
  - `i_stall` → `o_pc`
  - otherwise → `o_pc + 4`
- Redirects take effect even when `i_stall` = 1. Lower-priority redirects asserted in the same cycle are discarded.
- All adds are modulo 2^`ADDR_W`: PC `2^ADDR_W − 4` wraps to 0. Branch offsets wrap the same way.
- `o_redirect`: registered; 1 for one cycle after any of exc/jr/jump/branch was selected.
- `o_misalign`: registered; 1 when JR was selected and `i_jr_addr[1:0]` ≠ 0. The PC is still loaded, with bits [1:0] cleared.
- RAS is a circular buffer with a top pointer and count 0..`RAS_DEPTH`.
  - Push only: write entry, pointer +1. On full, the oldest entry is overwritten and count stays at `RAS_DEPTH`.
  - Pop only: pointer −1, count −1. Pop on empty is ignored.
  - Push and pop together: top entry replaced, count unchanged. On empty, this is treated as a push.
  - `i_exc` flushes the RAS (count = 0) and overrides any push or pop in the same cycle.
- RAS updates are not gated by `i_stall`.

## Timing
- Reset (asynchronous, while `i_rst_n` = 0): `o_pc` = `RESET_VEC`, `o_redirect` = 0, `o_misalign` = 0, RAS count = 0, `o_ras_valid` = 0, `o_ras_top` = 0. Reset asserted mid-operation aborts any pending redirect immediately.
- First edge after reset release with no requests: `o_pc` = `RESET_VEC` + 4.
- Control inputs sampled at edge t appear on `o_pc` / `o_redirect` / RAS outputs after edge t; one-cycle latency, no bubbles.
- `o_pc_plus4` and `o_ras_top` are combinational from registers only; there is no input-to-output combinational path.

## Structure
- Shared package `mips_pc_pkg`:
  - default vector constants
  - a `next_pc_sel` enum: RST, EXC, JR, JMP, BR, HOLD, SEQ
  - a function for the branch-target computation, for reuse by the decode comparator.
- Sub-module `pc_ras`: the stack, parameters `ADDR_W`, `RAS_DEPTH`; ports clk, rst, push, pop, flush, data in, top, valid.
- `pc_unit`: priority mux, PC register, flag registers.

## Test plan
- Reset `RESET_VEC` = 0x0, release, then 3 free cycles → `o_pc` = 0x0, 0x4, 0x8, 0xC; `o_redirect` = 0.
- `o_pc` = 0x100, `i_stall` = 1 for 2 cycles then `i_branch` = 1, `i_branch_pc` = 0x0F8, `i_branch_imm` = 0xFFFE → `o_pc` holds 0x100, then becomes 0x0F4 with `o_redirect` = 1 for one cycle.
- Same cycle: `i_exc`, `i_jr` (0x200), `i_jump` and `i_branch` → `o_pc` = 0x80. `i_jr_addr` = 0x203 alone → `o_pc` = 0x200, `o_misalign` = 1.
- `o_pc` = 0xFFFF_FFFC, free-run → `o_pc` = 0x0. `o_pc` = 0x1000_0000 with `i_jump_idx` = 0x0000040 → `o_pc` = 0x1000_0100.
- RAS with `RAS_DEPTH` = 4: push A, B, C, D, E → top = E, valid = 1. Four pops → tops D, C, B, then valid = 0. Fifth pop is ignored. Push and pop on an empty stack → top = the pushed value.
- RAS holds 2 entries, then `i_exc` together with `i_ras_push` → valid = 0, `o_pc` = 0x80. Assert `i_rst_n` = 0 mid-stall → outputs return to reset values without waiting for a clock edge.
